// File: rtl/nnoc_tile_pkg.sv
// Shared tile geometry, beat counter type and streamer FSM encoding for the tile datapath.
package nnoc_tile_pkg;

   localparam int unsigned DIM        = 4;
   localparam int unsigned TILE_ELEMS = DIM * DIM;
   localparam int unsigned SKEW_BEATS = 2 * DIM - 1;
   localparam int unsigned BEAT_W     = 3;

   typedef logic [BEAT_W-1:0] beat_t;

   localparam beat_t BEAT_LAST = beat_t'(SKEW_BEATS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CAPT   = 2'd1,
      STREAM = 2'd2
   } streamer_state_t;

   // Lane carries an element on this beat when 0 <= beat-lane <= DIM-1.
   function automatic logic lane_active(input beat_t beat, input beat_t lane);
      logic [BEAT_W:0] off;
      off = {1'b0, beat} - {1'b0, lane};
      return (beat >= lane) && (off < (BEAT_W+1)'(DIM));
   endfunction

endpackage

// File: rtl/tile_skew_streamer_if.sv
// Skewed-beat stream toward the systolic-array row input (valid/ready).
interface tile_skew_streamer_if
   import nnoc_tile_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) ();

   logic [DIM*WIDTH-1:0] out_data;
   logic [DIM-1:0]       out_lane_valid;
   logic                 out_valid;
   logic                 out_ready;

   modport master (
      output out_data,
      output out_lane_valid,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_lane_valid,
      input  out_valid,
      output out_ready
   );

endinterface

// File: rtl/tile_skew_mux.sv
// Selects the diagonal of the held tile for a given beat: lane i gets element (i, beat-i).
module tile_skew_mux
   import nnoc_tile_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic [TILE_ELEMS*WIDTH-1:0] tile_i,
   input  beat_t                       beat_i,
   output logic [DIM*WIDTH-1:0]        lane_data_c_o,
   output logic [DIM-1:0]              lane_valid_c_o
);

   logic [WIDTH-1:0] elem [DIM][DIM];

   for (genvar r = 0; r < DIM; r++) begin : g_row
      for (genvar c = 0; c < DIM; c++) begin : g_col
         assign elem[r][c] = tile_i[(r*DIM + c)*WIDTH +: WIDTH];
      end
   end

   for (genvar l = 0; l < DIM; l++) begin : g_lane
      logic [1:0] col;
      logic       act;

      // Column index wraps harmlessly when the lane is inactive; act masks it.
      assign col                             = 2'(beat_i - beat_t'(l));
      assign act                             = lane_active(beat_i, beat_t'(l));
      assign lane_valid_c_o[l]               = act;
      assign lane_data_c_o[l*WIDTH +: WIDTH] = act ? elem[l][col] : '0;
   end

endmodule

// File: rtl/tile_skew_streamer.sv
// Pops one 4x4 tile from the tile FIFO, holds it, and streams it as 7 diagonally skewed beats.
module tile_skew_streamer
   import nnoc_tile_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic                        fifo_empty,
   output logic                        fifo_rd,
   input  logic [TILE_ELEMS*WIDTH-1:0] fifo_data,
   tile_skew_streamer_if.master        out_if,
   output logic                        tile_done,
   output logic                        busy
);

   localparam int unsigned TILE_W = TILE_ELEMS * WIDTH;
   localparam int unsigned LANE_W = DIM * WIDTH;

   streamer_state_t    state_q, state_d;
   beat_t              beat_q, beat_d;
   logic [TILE_W-1:0]  tile_q, tile_d;
   logic               done_q, done_d;
   logic               armed_q;
   logic               rd_c;
   logic               streaming_c;
   logic [LANE_W-1:0]  mux_data_c;
   logic [DIM-1:0]     mux_valid_c;

   // armed_q keeps fifo_rd low through reset and the first edge after release.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         beat_q  <= '0;
         tile_q  <= '0;
         done_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         tile_q  <= tile_d;
         done_q  <= done_d;
         armed_q <= 1'b1;
      end
   end

   // Next-state: fetch only from IDLE; an in-flight tile always runs to beat 6.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      tile_d  = tile_q;
      done_d  = 1'b0;
      rd_c    = 1'b0;
      case (state_q)
         IDLE: begin
            if (armed_q && enable && !fifo_empty) begin
               rd_c    = 1'b1;
               state_d = CAPT;
            end
         end
         CAPT: begin
            tile_d  = fifo_data;
            beat_d  = '0;
            state_d = STREAM;
         end
         STREAM: begin
            if (out_if.out_ready) begin
               if (beat_q == BEAT_LAST) begin
                  beat_d  = '0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  beat_d = beat_q + beat_t'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   tile_skew_mux #(
      .WIDTH (WIDTH)
   ) u_mux (
      .tile_i         (tile_q),
      .beat_i         (beat_q),
      .lane_data_c_o  (mux_data_c),
      .lane_valid_c_o (mux_valid_c)
   );

   // Stream outputs depend only on registered state; gated to zero outside STREAM.
   assign streaming_c           = (state_q == STREAM);
   assign out_if.out_valid      = streaming_c;
   assign out_if.out_data       = streaming_c ? mux_data_c : '0;
   assign out_if.out_lane_valid = streaming_c ? mux_valid_c : '0;

   assign fifo_rd   = rd_c;
   assign tile_done = done_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_tile_skew_streamer.sv
// Directed bench for tile_skew_streamer: skew pattern, backpressure, back-to-back, gating, reset abort, WIDTH=8.
module tb_tile_skew_streamer;

   logic         clk;
   logic         reset;
   logic         enable;
   logic         fifo_empty;
   logic         fifo_rd;
   logic [255:0] fifo_data;
   logic         tile_done;
   logic         busy;

   logic         enable8;
   logic         fifo_empty8;
   logic         fifo_rd8;
   logic [127:0] fifo_data8;
   logic         tile_done8;
   logic         busy8;

   tile_skew_streamer_if #(.WIDTH(16)) sif ();
   tile_skew_streamer_if #(.WIDTH(8))  sif8 ();

   tile_skew_streamer #(.WIDTH(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .fifo_empty (fifo_empty),
      .fifo_rd    (fifo_rd),
      .fifo_data  (fifo_data),
      .out_if     (sif),
      .tile_done  (tile_done),
      .busy       (busy)
   );

   tile_skew_streamer #(.WIDTH(8)) dut8 (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable8),
      .fifo_empty (fifo_empty8),
      .fifo_rd    (fifo_rd8),
      .fifo_data  (fifo_data8),
      .out_if     (sif8),
      .tile_done  (tile_done8),
      .busy       (busy8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks;
   int failures;
   int cyc;
   int rd_cnt;
   int done_cnt;
   int busy_cnt;
   int idle_cyc;
   int done_cyc;
   bit was_busy;
   int rd_cyc[$];
   logic [67:0]  acc[$];
   logic [255:0] fifo_q[$];
   logic [63:0]  exp_d [7];
   logic [3:0]   exp_m [7];

   // Tile k: element (r,c) = r*4+c+1+16*k.
   function automatic logic [255:0] make_tile(input int k);
      logic [255:0] t;
      t = '0;
      for (int e = 0; e < 16; e++) t = t | (256'(e + 1 + 16*k) << (16*e));
      return t;
   endfunction

   function automatic logic [63:0] exp_beat(input logic [2:0] b, input int k);
      logic [63:0] add;
      add = '0;
      for (int l = 0; l < 4; l++)
         if (((exp_m[b] >> l) & 4'd1) != 4'd0) add = add | (64'(16*k) << (16*l));
      return exp_d[b] + add;
   endfunction

   task automatic push_tile(input int k);
      fifo_q.push_back(make_tile(k));
      fifo_empty = (fifo_q.size() == 0);
   endtask

   task automatic reset_counters();
      rd_cnt   = 0;
      done_cnt = 0;
      busy_cnt = 0;
      idle_cyc = -1;
      done_cyc = -1;
      rd_cyc.delete();
      acc.delete();
   endtask

   // One clock: called at negedge, returns at the next negedge with outputs sampled.
   task automatic cycle();
      logic rd_now;
      #1;
      rd_now = fifo_rd;
      if (rd_now) begin
         rd_cnt++;
         rd_cyc.push_back(cyc);
      end
      if (sif.out_valid && sif.out_ready) acc.push_back({sif.out_lane_valid, sif.out_data});
      @(posedge clk);
      #1;
      cyc++;
      if (rd_now) fifo_data = (fifo_q.size() > 0) ? fifo_q.pop_front() : '0;
      fifo_empty = (fifo_q.size() == 0);
      @(negedge clk);
      if (tile_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (busy) busy_cnt++;
      if (was_busy && !busy) idle_cyc = cyc;
      was_busy = busy;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      enable     = 1'b1;
      fifo_empty = 1'b0;
      #1;
      checks++; if (fifo_rd !== 1'b0) begin failures++; $display("FAIL rst_fifo_rd got %b exp 0", fifo_rd); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %b exp 0", busy); end
      checks++; if (sif.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got %b exp 0", sif.out_valid); end
      checks++; if (sif.out_lane_valid !== 4'b0) begin failures++; $display("FAIL rst_lane_valid got %b exp 0000", sif.out_lane_valid); end
      checks++; if (sif.out_data !== 64'h0) begin failures++; $display("FAIL rst_out_data got %h exp 0", sif.out_data); end
      checks++; if (tile_done !== 1'b0) begin failures++; $display("FAIL rst_tile_done got %b exp 0", tile_done); end
      reset = 1'b1;
      #1;
      checks++; if (fifo_rd !== 1'b0) begin failures++; $display("FAIL rst_release_fifo_rd got %b exp 0", fifo_rd); end
      fifo_empty = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || sif.out_valid !== 1'b0) begin
         failures++; $display("FAIL rst_first_edge busy=%b valid=%b exp 0 0", busy, sif.out_valid);
      end
      enable = 1'b0;
   endtask

   task automatic test_single();
      int span;
      reset_counters();
      enable        = 1'b1;
      sif.out_ready = 1'b1;
      push_tile(0);
      for (int i = 0; i < 40 && !(done_cnt >= 1 && !busy); i++) cycle();
      repeat (5) cycle();
      checks++; if (rd_cnt !== 1) begin failures++; $display("FAIL single_rd_cycles got %0d exp 1", rd_cnt); end
      checks++; if (acc.size() !== 7) begin failures++; $display("FAIL single_beats got %0d exp 7", acc.size()); end
      for (int i = 0; i < 7 && i < acc.size(); i++) begin
         checks++;
         if (acc[i] !== {exp_m[3'(i)], exp_beat(3'(i), 0)}) begin
            failures++; $display("FAIL single_beat%0d got %h exp %h", i, acc[i], {exp_m[3'(i)], exp_beat(3'(i), 0)});
         end
      end
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL single_done_pulses got %0d exp 1", done_cnt); end
      span = (rd_cyc.size() > 0) ? idle_cyc - rd_cyc[0] : -1;
      checks++; if (span !== 9) begin failures++; $display("FAIL single_span got %0d exp 9", span); end
      checks++; if (done_cyc !== idle_cyc) begin failures++; $display("FAIL single_done_cycle got %0d exp %0d", done_cyc, idle_cyc); end
   endtask

   task automatic test_backpressure();
      int stall;
      int span;
      reset_counters();
      enable = 1'b1;
      stall  = 0;
      push_tile(0);
      for (int i = 0; i < 50 && !(done_cnt >= 1 && !busy); i++) begin
         if (acc.size() == 2 && stall < 5) begin
            sif.out_ready = 1'b0;
            stall++;
            checks++;
            if ({sif.out_valid, sif.out_lane_valid, sif.out_data} !== {1'b1, exp_m[3'd2], exp_beat(3'd2, 0)}) begin
               failures++;
               $display("FAIL bp_hold%0d got %h exp %h", stall, {sif.out_valid, sif.out_lane_valid, sif.out_data},
                        {1'b1, exp_m[3'd2], exp_beat(3'd2, 0)});
            end
         end else begin
            sif.out_ready = 1'b1;
         end
         cycle();
      end
      sif.out_ready = 1'b1;
      checks++; if (stall !== 5) begin failures++; $display("FAIL bp_stall_cycles got %0d exp 5", stall); end
      checks++; if (acc.size() !== 7) begin failures++; $display("FAIL bp_beats got %0d exp 7", acc.size()); end
      for (int i = 0; i < 7 && i < acc.size(); i++) begin
         checks++;
         if (acc[i] !== {exp_m[3'(i)], exp_beat(3'(i), 0)}) begin
            failures++; $display("FAIL bp_beat%0d got %h exp %h", i, acc[i], {exp_m[3'(i)], exp_beat(3'(i), 0)});
         end
      end
      span = (rd_cyc.size() > 0) ? idle_cyc - rd_cyc[0] : -1;
      checks++; if (span !== 14) begin failures++; $display("FAIL bp_span got %0d exp 14", span); end
   endtask

   task automatic test_back_to_back();
      reset_counters();
      enable = 1'b1;
      push_tile(1);
      push_tile(2);
      push_tile(3);
      for (int i = 0; i < 80 && !(done_cnt >= 3 && !busy); i++) cycle();
      repeat (3) cycle();
      checks++; if (rd_cnt !== 3) begin failures++; $display("FAIL b2b_rd_count got %0d exp 3", rd_cnt); end
      for (int i = 1; i < rd_cyc.size(); i++) begin
         checks++;
         if (rd_cyc[i] - rd_cyc[i-1] !== 9) begin
            failures++; $display("FAIL b2b_rd_gap%0d got %0d exp 9", i, rd_cyc[i] - rd_cyc[i-1]);
         end
      end
      checks++; if (done_cnt !== 3) begin failures++; $display("FAIL b2b_done_pulses got %0d exp 3", done_cnt); end
      checks++; if (acc.size() !== 21) begin failures++; $display("FAIL b2b_beats got %0d exp 21", acc.size()); end
      for (int i = 0; i < 21 && i < acc.size(); i++) begin
         checks++;
         if (acc[i] !== {exp_m[3'(i % 7)], exp_beat(3'(i % 7), i / 7 + 1)}) begin
            failures++;
            $display("FAIL b2b_beat%0d got %h exp %h", i, acc[i], {exp_m[3'(i % 7)], exp_beat(3'(i % 7), i / 7 + 1)});
         end
      end
   endtask

   task automatic test_gating();
      reset_counters();
      enable = 1'b1;
      repeat (20) cycle();
      checks++; if (rd_cnt !== 0 || busy_cnt !== 0) begin
         failures++; $display("FAIL gate_empty rd=%0d busy_cycles=%0d exp 0 0", rd_cnt, busy_cnt);
      end
      enable = 1'b0;
      push_tile(0);
      repeat (20) cycle();
      checks++; if (rd_cnt !== 0 || busy_cnt !== 0) begin
         failures++; $display("FAIL gate_disabled rd=%0d busy_cycles=%0d exp 0 0", rd_cnt, busy_cnt);
      end
      enable = 1'b1;
      push_tile(1);
      for (int i = 0; i < 40 && !(done_cnt >= 1 && !busy); i++) begin
         if (acc.size() >= 1) enable = 1'b0;
         cycle();
      end
      repeat (15) cycle();
      checks++; if (rd_cnt !== 1) begin failures++; $display("FAIL gate_midtile_rd got %0d exp 1", rd_cnt); end
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL gate_midtile_done got %0d exp 1", done_cnt); end
      checks++; if (acc.size() !== 7) begin failures++; $display("FAIL gate_midtile_beats got %0d exp 7", acc.size()); end
      if (acc.size() == 7) begin
         checks++;
         if (acc[6] !== {exp_m[3'd6], exp_beat(3'd6, 0)}) begin
            failures++; $display("FAIL gate_midtile_last got %h exp %h", acc[6], {exp_m[3'd6], exp_beat(3'd6, 0)});
         end
      end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL gate_final_busy got %b exp 0", busy); end
      fifo_q.delete();
      fifo_empty = 1'b1;
   endtask

   task automatic test_reset_mid();
      reset_counters();
      enable = 1'b1;
      push_tile(0);
      push_tile(2);
      for (int i = 0; i < 40 && !(acc.size() >= 4 && sif.out_valid); i++) cycle();
      checks++; if (acc.size() !== 4 || sif.out_valid !== 1'b1) begin
         failures++; $display("FAIL rmid_reach_beat4 beats=%0d valid=%b exp 4 1", acc.size(), sif.out_valid);
      end
      reset = 1'b0;
      #1;
      checks++; if ({sif.out_valid, sif.out_lane_valid, sif.out_data} !== 69'h0) begin
         failures++; $display("FAIL rmid_stream_zero got %h exp 0", {sif.out_valid, sif.out_lane_valid, sif.out_data});
      end
      checks++; if ({busy, tile_done, fifo_rd} !== 3'b000) begin
         failures++; $display("FAIL rmid_ctrl_zero got %b exp 000", {busy, tile_done, fifo_rd});
      end
      repeat (2) cycle();
      checks++; if (done_cnt !== 0) begin failures++; $display("FAIL rmid_no_done got %0d exp 0", done_cnt); end
      reset = 1'b1;
      acc.delete();
      for (int i = 0; i < 40 && !(done_cnt >= 1 && !busy); i++) cycle();
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL rmid_restart_done got %0d exp 1", done_cnt); end
      checks++; if (acc.size() !== 7) begin failures++; $display("FAIL rmid_restart_beats got %0d exp 7", acc.size()); end
      for (int i = 0; i < 7 && i < acc.size(); i++) begin
         checks++;
         if (acc[i] !== {exp_m[3'(i)], exp_beat(3'(i), 2)}) begin
            failures++; $display("FAIL rmid_beat%0d got %h exp %h", i, acc[i], {exp_m[3'(i)], exp_beat(3'(i), 2)});
         end
      end
      enable = 1'b0;
   endtask

   task automatic test_width8();
      int beats;
      int dones;
      int rd8;
      logic rd_now;
      logic [31:0] e8;
      beats          = 0;
      dones          = 0;
      rd8            = 0;
      fifo_data8     = '1;
      sif8.out_ready = 1'b1;
      enable8        = 1'b1;
      fifo_empty8    = 1'b0;
      for (int i = 0; i < 40; i++) begin
         #1;
         rd_now = fifo_rd8;
         if (rd_now) rd8++;
         if (sif8.out_valid && sif8.out_ready) begin
            if (beats < 7) begin
               e8 = '0;
               for (int l = 0; l < 4; l++)
                  if (((exp_m[3'(beats)] >> l) & 4'd1) != 4'd0) e8 = e8 | (32'hFF << (8*l));
               checks++;
               if ({sif8.out_lane_valid, sif8.out_data} !== {exp_m[3'(beats)], e8}) begin
                  failures++;
                  $display("FAIL w8_beat%0d got %h exp %h", beats, {sif8.out_lane_valid, sif8.out_data},
                           {exp_m[3'(beats)], e8});
               end
            end
            beats++;
         end
         @(posedge clk);
         #1;
         if (rd_now) fifo_empty8 = 1'b1;
         @(negedge clk);
         if (tile_done8) dones++;
         if (dones > 0 && !busy8) break;
      end
      enable8 = 1'b0;
      checks++; if (beats !== 7) begin failures++; $display("FAIL w8_beats got %0d exp 7", beats); end
      checks++; if (dones !== 1) begin failures++; $display("FAIL w8_done got %0d exp 1", dones); end
      checks++; if (rd8 !== 1) begin failures++; $display("FAIL w8_rd got %0d exp 1", rd8); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      checks         = 0;
      failures       = 0;
      cyc            = 0;
      was_busy       = 1'b0;
      reset          = 1'b0;
      enable         = 1'b0;
      fifo_empty     = 1'b1;
      fifo_data      = '0;
      sif.out_ready  = 1'b1;
      enable8        = 1'b0;
      fifo_empty8    = 1'b1;
      fifo_data8     = '0;
      sif8.out_ready = 1'b1;
      reset_counters();

      exp_d[0] = {16'd0,  16'd0,  16'd0,  16'd1};  exp_m[0] = 4'b0001;
      exp_d[1] = {16'd0,  16'd0,  16'd5,  16'd2};  exp_m[1] = 4'b0011;
      exp_d[2] = {16'd0,  16'd9,  16'd6,  16'd3};  exp_m[2] = 4'b0111;
      exp_d[3] = {16'd13, 16'd10, 16'd7,  16'd4};  exp_m[3] = 4'b1111;
      exp_d[4] = {16'd14, 16'd11, 16'd8,  16'd0};  exp_m[4] = 4'b1110;
      exp_d[5] = {16'd15, 16'd12, 16'd0,  16'd0};  exp_m[5] = 4'b1100;
      exp_d[6] = {16'd16, 16'd0,  16'd0,  16'd0};  exp_m[6] = 4'b1000;

      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_gating();
      test_reset_mid();
      test_width8();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
